// File: rtl/fp32_pkg.sv
// fp32_pkg: shared single-precision float types for the fp32 arithmetic slice.
//   fp32_t    - packed IEEE-754 binary32 view {sign, exp, frac}
//   FP32_ZERO - positive zero, used as the reset value of operand registers
package fp32_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  localparam fp32_t FP32_ZERO = '{sign: 1'b0, exp: 8'h00, frac: 23'h000000};

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: purely combinational round-robin picker.
//   eligible  [N]        - request mask
//   ptr       [IW]       - index where the search starts (wraps modulo N)
//   grant     [N]        - one-hot winner, zero when nothing is eligible
//   grant_id  [IW]       - binary index of the winner
//   any_grant            - some requester won
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_id,
  output logic          any_grant
);

  int unsigned idx;

  // Walk N positions starting at ptr; the first eligible one wins.
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr) + k) % N;
      if (!any_grant && eligible[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = IW'(idx);
        any_grant  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp32_issue_arbiter.sv
// fp32_issue_arbiter: round-robin issue of operand pairs from NUM_REQ
// requesters into one shared, non-stalling, fixed-latency fp32 datapath, with
// tag tracking so each returned result is strobed back to its issuer.
//   clk_in, rst_in            - clock, synchronous active-high reset
//   req_valid_in/a_in/b_in    - per-requester operand pair offer
//   req_ready_out             - one-hot grant (zero during reset)
//   fp_valid_out/a_out/b_out  - registered issue into the datapath
//   fp_result_in              - datapath result, FP_LATENCY cycles after issue
//   result_valid_out          - one-hot result strobe
//   result_out                - registered result, shared by all requesters
module fp32_issue_arbiter
  import fp32_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned FP_LATENCY      = 4,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [NUM_REQ-1:0]       req_valid_in,
  input  logic [NUM_REQ-1:0][31:0] req_a_in,
  input  logic [NUM_REQ-1:0][31:0] req_b_in,
  output logic [NUM_REQ-1:0]       req_ready_out,
  output logic                     fp_valid_out,
  output logic [31:0]              fp_a_out,
  output logic [31:0]              fp_b_out,
  input  logic [31:0]              fp_result_in,
  output logic [NUM_REQ-1:0]       result_valid_out,
  output logic [31:0]              result_out
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  logic [IW-1:0]      rr_ptr;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      grant_id;
  logic               any_grant;

  logic [CW-1:0]      outstanding_q [NUM_REQ];

  fp32_t              fp_a_q;
  fp32_t              fp_b_q;
  logic [IW-1:0]      issue_id_q;

  logic               tag_valid_q [FP_LATENCY];
  logic [IW-1:0]      tag_id_q    [FP_LATENCY];

  // A capped requester whose result strobe is up this cycle may issue again:
  // the decrement and the new accept cancel in the counter.
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      eligible[i] = !rst_in && req_valid_in[i] &&
                    ((outstanding_q[i] < CW'(MAX_OUTSTANDING)) || result_valid_out[i]);
    end
  end

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr_arbiter (
    .eligible  (eligible),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_id  (grant_id),
    .any_grant (any_grant)
  );

  // eligible already includes req_valid_in, so a grant is a transfer.
  assign req_ready_out = grant;

  assign fp_a_out = fp_a_q;
  assign fp_b_out = fp_b_q;

  // Pointer and issue register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rr_ptr       <= '0;
      fp_valid_out <= 1'b0;
      fp_a_q       <= FP32_ZERO;
      fp_b_q       <= FP32_ZERO;
      issue_id_q   <= '0;
    end else begin
      fp_valid_out <= any_grant;
      if (any_grant) begin
        rr_ptr     <= (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + IW'(1);
        fp_a_q     <= fp32_t'(req_a_in[grant_id]);
        fp_b_q     <= fp32_t'(req_b_in[grant_id]);
        issue_id_q <= grant_id;
      end
    end
  end

  // Tag pipe shadows the datapath; its last entry lines up with fp_result_in.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int unsigned k = 0; k < FP_LATENCY; k++) begin
        tag_valid_q[k] <= 1'b0;
        tag_id_q[k]    <= '0;
      end
    end else begin
      tag_valid_q[0] <= fp_valid_out;
      tag_id_q[0]    <= issue_id_q;
      for (int unsigned k = 1; k < FP_LATENCY; k++) begin
        tag_valid_q[k] <= tag_valid_q[k-1];
        tag_id_q[k]    <= tag_id_q[k-1];
      end
    end
  end

  // Return register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      result_valid_out <= '0;
      result_out       <= '0;
    end else begin
      result_valid_out <= '0;
      if (tag_valid_q[FP_LATENCY-1]) begin
        result_valid_out[tag_id_q[FP_LATENCY-1]] <= 1'b1;
        result_out                               <= fp_result_in;
      end
    end
  end

  // Outstanding counters.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        outstanding_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        case ({grant[i], result_valid_out[i]})
          2'b10:   outstanding_q[i] <= outstanding_q[i] + CW'(1);
          2'b01:   outstanding_q[i] <= outstanding_q[i] - CW'(1);
          default: outstanding_q[i] <= outstanding_q[i];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fp32_issue_arbiter.sv
module tb_fp32_issue_arbiter;

  localparam int N = 4;
  localparam int L = 4;
  localparam int M = 2;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Main DUT (MAX_OUTSTANDING=2)
  logic                 rst_in;
  logic [N-1:0]         req_valid_in;
  logic [N-1:0][31:0]   req_a_in, req_b_in;
  logic [N-1:0]         req_ready_out;
  logic                 fp_valid_out;
  logic [31:0]          fp_a_out, fp_b_out, fp_result_in;
  logic [N-1:0]         result_valid_out;
  logic [31:0]          result_out;

  // Stream DUT (MAX_OUTSTANDING=8)
  logic                 rst8;
  logic [N-1:0]         valid8;
  logic [N-1:0][31:0]   a8_in, b8_in;
  logic [N-1:0]         ready8;
  logic                 fpv8;
  logic [31:0]          fpa8, fpb8, fpr8;
  logic [N-1:0]         rv8;
  logic [31:0]          ro8;

  fp32_issue_arbiter #(.NUM_REQ(N), .FP_LATENCY(L), .MAX_OUTSTANDING(M)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .req_valid_in(req_valid_in),
    .req_a_in(req_a_in), .req_b_in(req_b_in), .req_ready_out(req_ready_out),
    .fp_valid_out(fp_valid_out), .fp_a_out(fp_a_out), .fp_b_out(fp_b_out),
    .fp_result_in(fp_result_in), .result_valid_out(result_valid_out),
    .result_out(result_out)
  );

  fp32_issue_arbiter #(.NUM_REQ(N), .FP_LATENCY(L), .MAX_OUTSTANDING(8)) dut8 (
    .clk_in(clk_in), .rst_in(rst8), .req_valid_in(valid8),
    .req_a_in(a8_in), .req_b_in(b8_in), .req_ready_out(ready8),
    .fp_valid_out(fpv8), .fp_a_out(fpa8), .fp_b_out(fpb8),
    .fp_result_in(fpr8), .result_valid_out(rv8), .result_out(ro8)
  );

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    else
      n_pass++;
  endtask

  // fp32 <-> real via double bit layout (normal numbers only)
  function automatic real fp2r(input logic [31:0] f);
    logic [63:0] d;
    d = {f[31], 11'(int'(f[30:23]) + 896), f[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2fp(input real r);
    logic [63:0] d;
    int e;
    d = $realtobits(r);
    e = int'(d[62:52]) - 896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    return r2fp(fp2r(a) * fp2r(b));
  endfunction

  // Operands with short mantissas so products are exact in fp32.
  function automatic logic [31:0] gen_fp();
    logic [31:0] r;
    r = $urandom;
    return {r[31], 8'(110 + (r[7:0] % 35)), r[11:8], 19'b0};
  endfunction

  // Behavioural datapaths: product emerges L cycles after issue.
  logic [31:0] dp_pipe [L];
  logic [31:0] dp8_pipe [L];
  always @(posedge clk_in) begin
    dp_pipe[0]  <= fp_valid_out ? fmul(fp_a_out, fp_b_out) : 32'hDEADBEEF;
    dp8_pipe[0] <= fpv8 ? fmul(fpa8, fpb8) : 32'hDEADBEEF;
    for (int k = 1; k < L; k++) begin
      dp_pipe[k]  <= dp_pipe[k-1];
      dp8_pipe[k] <= dp8_pipe[k-1];
    end
  end
  assign fp_result_in = dp_pipe[L-1];
  assign fpr8         = dp8_pipe[L-1];

  // Reference model: in-flight queue with due cycles, per-requester counts.
  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    int          due;
  } inf_t;

  inf_t        m_q[$];
  int          m_cnt[N] = '{default: 0};
  int          m_ptr = 0;
  logic        m_fpv = 1'b0;
  logic [31:0] m_fa = '0, m_fb = '0, m_ro = '0;

  always @(negedge clk_in) begin : model
    logic [N-1:0] exp_rv, elig, exp_rdy;
    int g, idx;
    inf_t e;
    exp_rv = '0;
    if (m_q.size() > 0 && m_q[0].due == cyc) begin
      exp_rv[m_q[0].id] = 1'b1;
      m_ro = fmul(m_q[0].a, m_q[0].b);
    end
    for (int i = 0; i < N; i++)
      elig[i] = !rst_in && req_valid_in[i] && (m_cnt[i] < M || exp_rv[i]);
    g = -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (g < 0 && elig[idx]) g = idx;
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;

    chk("m_ready", 64'(req_ready_out), 64'(exp_rdy));
    chk("m_result_valid", 64'(result_valid_out), 64'(exp_rv));
    chk("m_result_out", 64'(result_out), 64'(m_ro));
    chk("m_fp_valid", 64'(fp_valid_out), 64'(m_fpv));
    chk("m_fp_a", 64'(fp_a_out), 64'(m_fa));
    chk("m_fp_b", 64'(fp_b_out), 64'(m_fb));
    for (int i = 0; i < N; i++)
      chk("m_outstanding", 64'(dut.outstanding_q[i]), 64'(m_cnt[i]));

    if (rst_in) begin
      m_q.delete();
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      m_ptr = 0; m_fpv = 1'b0; m_fa = '0; m_fb = '0; m_ro = '0;
    end else begin
      if (exp_rv != '0) begin
        m_cnt[m_q[0].id]--;
        void'(m_q.pop_front());
      end
      if (g >= 0) begin
        e.id = g; e.a = req_a_in[g]; e.b = req_b_in[g]; e.due = cyc + L + 2;
        m_q.push_back(e);
        m_cnt[g]++;
        m_ptr = (g + 1) % N;
        m_fpv = 1'b1; m_fa = req_a_in[g]; m_fb = req_b_in[g];
      end else begin
        m_fpv = 1'b0;
      end
    end
  end

  // Collector for the stream DUT
  logic [31:0]  got8[$];
  logic [N-1:0] gid8[$];
  always @(negedge clk_in) begin
    if (rv8 != '0) begin
      got8.push_back(ro8);
      gid8.push_back(rv8);
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      req_a_in[i] = gen_fp();
      req_b_in[i] = gen_fp();
    end
  endtask

  typedef struct {
    logic [N-1:0] v;
    logic [N-1:0] rdy;
    logic [N-1:0] rv;
  } vec_t;

  vec_t        tbl[10];
  logic [31:0] s_a[20], s_b[20];
  int          waited;

  initial begin
    rst_in = 1'b1; req_valid_in = '0; req_a_in = '0; req_b_in = '0;
    rst8 = 1'b1; valid8 = '0; a8_in = '0; b8_in = '0;

    // Sequence from reset: {valid, expected ready, expected result strobe}
    tbl[0] = '{4'b1111, 4'b0001, 4'b0000};
    tbl[1] = '{4'b1111, 4'b0010, 4'b0000};
    tbl[2] = '{4'b0000, 4'b0000, 4'b0000};
    tbl[3] = '{4'b1001, 4'b1000, 4'b0000};
    tbl[4] = '{4'b0110, 4'b0010, 4'b0000};
    tbl[5] = '{4'b0010, 4'b0000, 4'b0000};
    tbl[6] = '{4'b0011, 4'b0001, 4'b0001};
    tbl[7] = '{4'b0010, 4'b0010, 4'b0010};
    tbl[8] = '{4'b0100, 4'b0100, 4'b0000};
    tbl[9] = '{4'b1111, 4'b1000, 4'b1000};

    repeat (3) step();
    // Reset priority: nothing granted while rst_in is high
    req_valid_in = 4'b1111;
    #1 chk("ready_in_reset", 64'(req_ready_out), 64'd0);
    step();
    rst_in = 1'b0; rst8 = 1'b0;

    for (int i = 0; i < 10; i++) begin
      req_valid_in = tbl[i].v;
      rand_ops();
      #2;
      chk($sformatf("tbl_ready[%0d]", i), 64'(req_ready_out), 64'(tbl[i].rdy));
      chk($sformatf("tbl_rv[%0d]", i), 64'(result_valid_out), 64'(tbl[i].rv));
      step();
    end
    req_valid_in = '0;
    repeat (12) step();

    // Single request from requester 2: 2.0 * 3.0
    req_valid_in = 4'b0100;
    req_a_in[2] = 32'h40000000; req_b_in[2] = 32'h40400000;
    #2 chk("single_ready", 64'(req_ready_out), 64'h4);
    step();
    req_valid_in = '0;
    #2;
    chk("single_fp_valid", 64'(fp_valid_out), 64'd1);
    chk("single_fp_a", 64'(fp_a_out), 64'h40000000);
    chk("single_fp_b", 64'(fp_b_out), 64'h40400000);
    for (int k = 2; k <= 6; k++) begin
      step();
      #2;
      if (k < 6) chk("single_no_strobe", 64'(result_valid_out), 64'd0);
    end
    chk("single_rv", 64'(result_valid_out), 64'h4);
    chk("single_result", 64'(result_out), 64'h40C00000);
    repeat (6) step();

    // Outstanding cap on requester 0 alone
    for (int k = 0; k < 8; k++) begin
      req_valid_in = 4'b0001;
      rand_ops();
      #2 chk($sformatf("cap_ready[%0d]", k), 64'(req_ready_out[0]),
             64'((k < 2 || k >= 6) ? 1 : 0));
      step();
    end
    req_valid_in = '0;
    repeat (12) step();

    // Reset mid-flight
    for (int k = 0; k < 3; k++) begin
      req_valid_in = 4'b1111;
      rand_ops();
      step();
    end
    req_valid_in = '0;
    step();
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #2 chk("rst_no_strobe", 64'(result_valid_out), 64'd0);
      step();
    end
    for (int i = 0; i < N; i++)
      chk("rst_counter", 64'(dut.outstanding_q[i]), 64'd0);
    req_valid_in = 4'b1111;
    #2 chk("rst_first_grant", 64'(req_ready_out), 64'h1);
    step();
    req_valid_in = '0;
    repeat (12) step();

    // Randomized traffic against the model
    for (int k = 0; k < 1500; k++) begin
      req_valid_in = N'($urandom);
      rand_ops();
      rst_in = ($urandom_range(0, 249) == 0);
      step();
    end
    rst_in = 1'b0;
    req_valid_in = '0;
    repeat (12) step();

    // Back-to-back stream, requester 3, cap 8
    for (int i = 0; i < 20; i++) begin
      s_a[i] = gen_fp();
      s_b[i] = gen_fp();
      valid8 = 4'b1000;
      a8_in[3] = s_a[i]; b8_in[3] = s_b[i];
      #2 chk($sformatf("stream_ready[%0d]", i), 64'(ready8), 64'h8);
      step();
    end
    valid8 = '0;
    waited = 0;
    while (got8.size() < 20 && waited < 40) begin
      step();
      waited++;
    end
    chk("stream_count", 64'(got8.size()), 64'd20);
    for (int i = 0; i < 20; i++) begin
      if (i < got8.size()) begin
        chk($sformatf("stream_id[%0d]", i), 64'(gid8[i]), 64'h8);
        chk($sformatf("stream_data[%0d]", i), 64'(got8[i]), 64'(fmul(s_a[i], s_b[i])));
      end
    end
    step();
    chk("stream_counter", 64'(dut8.outstanding_q[3]), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
